first_counter: RTL and testbench
================================

# first_counter

Free-running-when-enabled binary up counter, 4 bits wide by default. It has a synchronous active-high reset and a count enable. It is a leaf block used as a basic event or cycle counter: it holds its value when disabled, wraps modulo 2^WIDTH, and drives its count directly from a register with no combinational path from the inputs.

## Interface
- WIDTH, default 4: counter width in bits. Legal range is 1 to 32. All arithmetic is modulo 2^WIDTH.
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- enable  input  1  count enable, active-high, sampled on the rising edge of clock.
- counter_out  output  WIDTH (4)  current count, driven straight from the count register.
- Port order is clock, reset, enable, counter_out. Positional instantiation relies on this order.

## Operation
- The block holds one WIDTH-bit register, count. counter_out equals count at all times, with no extra logic after the register.
- On each rising edge of clock, in priority order:
  - reset = 1: count <= 0, regardless of enable.
  - reset = 0 and enable = 1: count <= count + 1, modulo 2^WIDTH.
  - reset = 0 and enable = 0: count holds its value.
- Wrap-around: from all-ones (15 for WIDTH=4), an enabled edge gives 0. There is no terminal-count flag, no saturation, and no overflow output.
- Simultaneous reset and enable: reset wins, so count = 0 after the edge. Counting resumes on the first edge where reset = 0 and enable = 1.
- Reset mid-count: the next rising edge clears the count to 0, whatever value it held before.
- Power-up: the value before the first reset edge is undefined (X in simulation). No initial value is required. Users must assert reset for at least one rising edge before relying on the count.
- X or Z on enable while reset = 0 may corrupt the count. No protection is required.

## Timing
- Latency is one clock. counter_out changes only just after a rising edge of clock, never between edges.
- Changes to reset and enable between edges have no effect on counter_out until the next rising edge.
- Reset cost:
  - Reset must be held high across at least one rising edge.
  - counter_out reads 0 from just after that edge.
- Count rate:
  - N consecutive enabled, non-reset edges advance the count by exactly N (mod 2^WIDTH).
  - Dropping enable freezes the value at the last increment.
- Hold and clear:
  - With reset = 0 and enable = 0, the count stays constant forever.
  - With reset held high, the count stays 0 forever.
- Fmax target: one WIDTH-bit incrementer plus a 2:1 hold mux and a reset AND in front of the flops. There is no other logic in the path.

## Test plan
- Reset from unknown:
  - Stimulus: clock period 10 (starting high, so rising edges at t=10, 20, …), enable = 0, reset = 1 over t=5–15.
  - Response: counter_out is 0 after the edge at t=10, and stays 0 through t=25 with enable low.
- Counting, then hold:
  - Stimulus: after that reset, enable = 1 from t=25 to t=125.
  - Response: counter_out steps 1, 2, …, 10 on the edges at t=30…120. It reads 10 (4'b1010) after t=120 and holds 10 once enable drops.
- Wrap-around:
  - Stimulus: from reset, hold enable high for 17 edges.
  - Response: the sequence 1…15, 0, 1. The value after 16 edges is 0.
- Reset priority:
  - Stimulus: count to 7, then assert reset and enable together for one edge.
  - Response: counter_out = 0. With reset low and enable still high, the next edge gives 1.
- Hold with enable low:
  - Stimulus: count to 5, then enable = 0 for 20 edges.
  - Response: counter_out stays at 5 on every edge.
- Mid-cycle glitch:
  - Stimulus: pulse enable high for 2 time units between two rising edges.
  - Response: counter_out does not change.

Source files
------------

// File: rtl/first_counter.sv
// rtl/first_counter.sv - enable-gated binary up counter with synchronous reset
module first_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out
);

    logic [WIDTH-1:0] count;

    // Reset outranks enable; the increment wraps naturally at WIDTH bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign counter_out = count;

endmodule

// File: tb/tb_first_counter.sv
// tb/tb_first_counter.sv - directed self-checking bench for first_counter
module tb_first_counter;

    logic       clock = 1'b1;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] counter_out;

    int assertions = 0;
    int failures = 0;

    first_counter #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .counter_out (counter_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed %0d, expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        step();
        reset = 1'b0;
        check("reset_clear", {28'd0, counter_out}, 32'd0);
    endtask

    initial begin
        // Reset from unknown: reset high over t=5..15, edge at t=10.
        @(negedge clock);
        reset = 1'b1;
        step();
        check("reset_t15", {28'd0, counter_out}, 32'd0);
        reset = 1'b0;
        step();
        check("reset_hold_t25", {28'd0, counter_out}, 32'd0);

        // Counting 1..10 on edges t=30..120, then hold at 10.
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("count_%0d", i), {28'd0, counter_out}, i);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_after_count", {28'd0, counter_out}, 32'd10);
        end

        // Wrap-around over 17 enabled edges.
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            check($sformatf("wrap_%0d", i), {28'd0, counter_out}, i % 16);
        end

        // Reset priority over enable.
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        check("prio_at_7", {28'd0, counter_out}, 32'd7);
        reset = 1'b1;
        step();
        check("prio_reset_wins", {28'd0, counter_out}, 32'd0);
        reset = 1'b0;
        step();
        check("prio_resume", {28'd0, counter_out}, 32'd1);

        // Reset held high keeps zero even with enable asserted.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_held", {28'd0, counter_out}, 32'd0);
        end
        reset = 1'b0;

        // Hold with enable low for 20 edges.
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("hold5_%0d", i), {28'd0, counter_out}, 32'd5);
        end

        // Mid-cycle enable glitch between edges is ignored.
        #1 enable = 1'b1;
        #2 enable = 1'b0;
        check("glitch_mid", {28'd0, counter_out}, 32'd5);
        step();
        check("glitch_next_edge", {28'd0, counter_out}, 32'd5);

        // Mid-cycle reset glitch is likewise ignored.
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        step();
        check("reset_glitch", {28'd0, counter_out}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
